// File: rtl/ws2812b_tx.sv
// rtl/ws2812b_tx.sv - WS2812B one-wire NRZ serialiser for a NUM_LEDS x 24-bit GRB frame
module ws2812b_tx #(
    parameter int NUM_LEDS = 4,
    parameter int T0H      = 40,
    parameter int T0L      = 85,
    parameter int T1H      = 80,
    parameter int T1L      = 45,
    parameter int TRESET   = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [24*NUM_LEDS-1:0]    frame,
    input  logic                      start,
    output logic                      dout,
    output logic                      busy,
    output logic                      done
);

    localparam int FW      = 24 * NUM_LEDS;
    localparam int MAX_H   = (T0H > T1H) ? T0H : T1H;
    localparam int MAX_L   = (T0L > T1L) ? T0L : T1L;
    localparam int MAX_BIT = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int MAX_T   = (TRESET > MAX_BIT) ? TRESET : MAX_BIT;
    localparam int CW      = $clog2(MAX_T + 1);
    localparam int IW      = $clog2(FW);

    // Phase counter is loaded with (duration - 1) and counts down to zero.
    localparam logic [CW-1:0] H0  = CW'(T0H - 1);
    localparam logic [CW-1:0] H1  = CW'(T1H - 1);
    localparam logic [CW-1:0] L0  = CW'(T0L - 1);
    localparam logic [CW-1:0] L1  = CW'(T1L - 1);
    localparam logic [CW-1:0] RST = CW'(TRESET - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [FW-1:0]   shreg, shreg_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            done_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            idx   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
            dout  <= (state_nxt == HIGH);
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt = frame;
                    idx_nxt   = IW'(FW - 1);
                    cnt_nxt   = frame[FW-1] ? H1 : H0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    cnt_nxt   = shreg[FW-1] ? L1 : L0;
                    state_nxt = LOW;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            LOW: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (idx == '0) begin
                    cnt_nxt   = RST;
                    state_nxt = LATCH;
                end else begin
                    // Next bit's high time comes from the bit about to shift into the MSB.
                    shreg_nxt = {shreg[FW-2:0], 1'b0};
                    idx_nxt   = idx - IW'(1);
                    cnt_nxt   = shreg[FW-2] ? H1 : H0;
                    state_nxt = HIGH;
                end
            end
            LATCH: begin
                if (cnt == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ws2812b_tx.sv
// tb/tb_ws2812b_tx.sv - randomized self-checking bench for ws2812b_tx against a timing-offset model
module tb_ws2812b_tx;

    localparam int FW     = 96;
    localparam int BIT_T  = 125;
    localparam int TRES   = 5000;
    localparam int BUSY_T = FW * BIT_T + TRES;
    localparam logic [FW-1:0] STRIPES = 96'hFFFFFF_000000_FFFFFF_000000;
    localparam logic [FW-1:0] A5      = 96'hA5A5A5A5A5A5A5A5A5A5A5A5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [FW-1:0] frame = '0;
    logic          dout, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ws2812b_tx dut (
        .clk   (clk),
        .reset (reset),
        .frame (frame),
        .start (start),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a frame is just "cycles since acceptance"; dout follows from bit time arithmetic.
    int            m_t = -1;
    logic          m_done = 1'b0;
    logic [FW-1:0] m_frame = '0;

    function automatic logic model_dout(input int t, input logic [FW-1:0] f);
        if (t < 0 || t >= FW * BIT_T) return 1'b0;
        return (t % BIT_T) < (f[FW - 1 - t / BIT_T] ? 80 : 40);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t    = -1;
            m_done = 1'b0;
        end else if (m_t >= 0) begin
            m_t++;
            m_done = 1'b0;
            if (m_t == BUSY_T) begin
                m_t    = -1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_t     = 0;
                m_frame = frame;
            end
        end
    end

    logic cmp_on = 1'b0;
    int   wave_err = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            if (dout !== model_dout(m_t, m_frame) || busy !== (m_t >= 0) || done !== m_done)
                wave_err++;
        end
    end

    // Independent decoder: classify each high pulse by width.
    logic bits[$];
    int   hi = 0;
    int   bad_pulse = 0;
    always @(negedge clk) begin
        if (dout === 1'b1) begin
            hi++;
        end else if (hi > 0) begin
            bits.push_back(hi > 60);
            if (hi != 40 && hi != 80) bad_pulse++;
            hi = 0;
        end
    end

    task automatic wave_check(input string tag);
        check({tag, "_wave"}, wave_err, 0);
        wave_err = 0;
    endtask

    task automatic decoded_check(input string tag, input logic [FW-1:0] exp);
        logic [FW-1:0] v;
        v = '0;
        foreach (bits[i]) v = {v[FW-2:0], bits[i]};
        check({tag, "_nbits"}, bits.size(), FW);
        check({tag, "_data"}, v, exp);
        check({tag, "_pulses"}, bad_pulse, 0);
        bits.delete();
        bad_pulse = 0;
    endtask

    function automatic logic [FW-1:0] rnd_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic send_and_run(input string tag, input logic [FW-1:0] f,
                                input int poke_at, input logic [FW-1:0] poke_f);
        int first_done = 0;
        int ndone = 0;
        int nbusy = 0;
        bits.delete();
        bad_pulse = 0;
        @(posedge clk); #2 frame = f; start = 1'b1;
        @(posedge clk); #2 start = 1'b0; frame = ~f;
        for (int n = 1; n <= BUSY_T + 100; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = n;
            end
            if (n == poke_at) begin
                frame = poke_f;
                start = 1'b1;
            end
            if (n == poke_at + 1) start = 1'b0;
        end
        check({tag, "_done_at"}, first_done, BUSY_T + 1);
        check({tag, "_busy_len"}, nbusy, BUSY_T);
        check({tag, "_done_cnt"}, ndone, 1);
        decoded_check(tag, f);
        wave_check(tag);
    endtask

    initial begin
        int quiet;
        int dones;
        int d1, d2, nd, gap;
        logic [FW-1:0] f;

        @(posedge clk);
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #2 reset = 1'b0;
        quiet = 0;
        repeat (100) begin
            @(negedge clk);
            if (dout || busy || done) quiet++;
        end
        check("idle_quiet", quiet, 0);
        wave_check("idle");

        send_and_run("zeros", '0, 0, '0);
        send_and_run("stripes", STRIPES, 500, rnd_frame());

        // Abort mid-frame at the start of bit 24, where dout is high.
        f = rnd_frame();
        @(posedge clk); #2 frame = f; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int n = 1; n <= 3001; n++) @(negedge clk);
        check("pre_reset_dout", dout, 1);
        #2 reset = 1'b1;
        #1;
        check("async_dout", dout, 0);
        check("async_busy", busy, 0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        @(posedge clk); #2 reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("reset_no_done", dones, 0);
        bits.delete();
        bad_pulse = 0;
        wave_check("reset");

        // start held high: back-to-back frames with only the done cycle between them.
        d1 = 0; d2 = 0; nd = 0; gap = 0;
        @(posedge clk); #2 frame = A5; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 2 * (BUSY_T + 1) + 100; n++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = n;
                    decoded_check("rep1", A5);
                end else begin
                    d2 = n;
                    start = 1'b0;
                    break;
                end
            end
            if (nd == 1 && !busy) gap++;
        end
        check("rep_first_done", d1, BUSY_T + 1);
        check("rep_period", d2 - d1, BUSY_T + 1);
        check("rep_idle_gap", gap, 1);
        decoded_check("rep2", A5);
        repeat (50) @(negedge clk);
        wave_check("repeat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
